// File: rtl/usb2_ep_in_arbiter_if.sv
// Bundles the two requester byte streams, the IN endpoint buffer write port and
// arbiter status. master = arbiter side, slave = requesters/endpoint side.
interface usb2_ep_in_arbiter_if;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned LEN_W  = 10;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;

  logic [ADDR_W-1:0] buf_in_addr;
  logic [DATA_W-1:0] buf_in_data;
  logic              buf_in_wren;
  logic              buf_in_ready;
  logic              buf_in_commit;
  logic [LEN_W-1:0]  buf_in_commit_len;
  logic              buf_in_commit_ack;

  logic [1:0]        grant;
  logic              busy;

  modport master (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    output buf_in_addr, buf_in_data, buf_in_wren,
    input  buf_in_ready,
    output buf_in_commit, buf_in_commit_len,
    input  buf_in_commit_ack,
    output grant, busy
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    input  buf_in_addr, buf_in_data, buf_in_wren,
    output buf_in_ready,
    input  buf_in_commit, buf_in_commit_len,
    output buf_in_commit_ack,
    input  grant, busy
  );
endinterface

// File: rtl/usb2_ep_in_arbiter.sv
// Round-robin arbiter sharing the USB 2.0 IN endpoint buffer write port between
// two byte-stream requesters; packs into <=MAX_LEN packets and commits each one.
module usb2_ep_in_arbiter #(
  parameter int unsigned MAX_LEN = 512
) (
  input  logic            ext_clk,
  input  logic            reset,
  usb2_ep_in_arbiter_if.master bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned CNT_W  = 10;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_FILL    = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;
  localparam logic [1:0] S_ACK_LOW = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              hold_q, hold_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              commit_q, commit_d;
  logic [CNT_W-1:0]  len_q, len_d;

  logic              room_c;
  logic              ready0_c;
  logic              ready1_c;
  logic              accept_c;
  logic              own_last_c;
  logic [DATA_W-1:0] own_data_c;

  // Byte acceptance is combinational so a stream can move one byte per cycle.
  assign room_c     = count_q < CNT_W'(MAX_LEN);
  assign ready0_c   = grant_q[0] & (state_q == S_FILL) & room_c;
  assign ready1_c   = grant_q[1] & (state_q == S_FILL) & room_c;
  assign accept_c   = (ready0_c & bus.req0_valid) | (ready1_c & bus.req1_valid);
  assign own_last_c = owner_q ? bus.req1_last : bus.req0_last;
  assign own_data_c = owner_q ? bus.req1_data : bus.req0_data;

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    hold_d       = hold_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    wren_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    commit_d     = commit_q;
    len_d        = len_q;

    case (state_q)
      S_IDLE: begin
        if (bus.buf_in_ready && (bus.req0_valid || bus.req1_valid)) begin
          // A split transfer keeps its owner; otherwise alternate on a tie.
          if (hold_q) begin
            owner_d = last_grant_q;
          end else if (bus.req0_valid && bus.req1_valid) begin
            owner_d = ~last_grant_q;
          end else begin
            owner_d = bus.req1_valid;
          end
          grant_d = owner_d ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          count_d = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (accept_c) begin
          wren_d  = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = own_data_c;
          count_d = count_q + CNT_W'(1);
          if (own_last_c) begin
            hold_d  = 1'b0;
            state_d = S_COMMIT;
          end else if ((count_q + CNT_W'(1)) == CNT_W'(MAX_LEN)) begin
            hold_d  = 1'b1;
            state_d = S_COMMIT;
          end
        end
      end

      S_COMMIT: begin
        // Ack is only honoured once commit has been visible for a cycle.
        commit_d = 1'b1;
        len_d    = count_q;
        if (commit_q && bus.buf_in_commit_ack) begin
          commit_d = 1'b0;
          state_d  = S_ACK_LOW;
        end
      end

      S_ACK_LOW: begin
        if (!bus.buf_in_commit_ack) begin
          last_grant_d = owner_q;
          grant_d      = 2'b00;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ext_clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      hold_q       <= 1'b0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      wren_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      commit_q     <= 1'b0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      hold_q       <= hold_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      wren_q       <= wren_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      commit_q     <= commit_d;
      len_q        <= len_d;
    end
  end

  assign bus.req0_ready        = ready0_c;
  assign bus.req1_ready        = ready1_c;
  assign bus.buf_in_wren       = wren_q;
  assign bus.buf_in_addr       = addr_q;
  assign bus.buf_in_data       = data_q;
  assign bus.buf_in_commit     = commit_q;
  assign bus.buf_in_commit_len = len_q;
  assign bus.grant             = grant_q;
  assign bus.busy              = busy_q;
endmodule

// File: tb/tb_usb2_ep_in_arbiter.sv
// Directed bench for usb2_ep_in_arbiter (MAX_LEN=4): queued byte sources, an
// auto-acking endpoint model, write/commit monitors and hand-computed expectations.
module tb_usb2_ep_in_arbiter;
  logic ext_clk;
  logic reset;

  usb2_ep_in_arbiter_if bus ();

  usb2_ep_in_arbiter #(.MAX_LEN(4)) dut (
    .ext_clk (ext_clk),
    .reset   (reset),
    .bus     (bus.master)
  );

  initial ext_clk = 1'b0;
  always #5 ext_clk = ~ext_clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  src0[$];
  logic [8:0]  src1[$];
  logic        en0, en1;
  logic        acc0, acc1;
  int          nacc0;
  int          cyc;
  int          last_acc;

  logic [18:0] wr_q[$];
  logic [9:0]  cl_q[$];
  logic [1:0]  cg_q[$];
  int          n_commit;
  int          commit_cyc;
  logic [9:0]  len_cap;
  logic        commit_prev;
  int          n_overlap, n_rdy_in_commit, n_unstable;

  int          ack_dly, ack_hold, ack_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Handshake sampling on the active edge: what the DUT actually took.
  initial begin
    cyc = 0;
    forever begin
      @(posedge ext_clk);
      cyc++;
      if (bus.req0_valid && bus.req0_ready) begin
        acc0 = 1'b1;
        nacc0++;
        if (bus.req0_last) last_acc = cyc;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        acc1 = 1'b1;
        if (bus.req1_last) last_acc = cyc;
      end
    end
  end

  // Byte sources: present head of queue, pop on acceptance.
  initial begin
    logic [8:0] dummy;
    forever begin
      @(negedge ext_clk);
      if (acc0 && src0.size() > 0) dummy = src0.pop_front();
      if (acc1 && src1.size() > 0) dummy = src1.pop_front();
      acc0 = 1'b0;
      acc1 = 1'b0;
      bus.req0_valid = en0 && (src0.size() > 0);
      bus.req0_data  = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
      bus.req0_last  = (src0.size() > 0) ? src0[0][8] : 1'b0;
      bus.req1_valid = en1 && (src1.size() > 0);
      bus.req1_data  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
      bus.req1_last  = (src1.size() > 0) ? src1[0][8] : 1'b0;
    end
  end

  // Endpoint model: ack after ack_dly commit cycles, release after ack_hold.
  initial begin
    forever begin
      @(negedge ext_clk);
      if (bus.buf_in_commit && !bus.buf_in_commit_ack) begin
        ack_cnt++;
        if (ack_cnt >= ack_dly) begin
          bus.buf_in_commit_ack = 1'b1;
          ack_cnt = 0;
        end
      end else if (bus.buf_in_commit_ack && !bus.buf_in_commit) begin
        ack_cnt++;
        if (ack_cnt >= ack_hold) begin
          bus.buf_in_commit_ack = 1'b0;
          ack_cnt = 0;
        end
      end
    end
  end

  // Monitor: write log, commit log and protocol violation counters.
  initial begin
    forever begin
      @(negedge ext_clk);
      if (!reset) begin
        if (bus.buf_in_wren) wr_q.push_back({bus.grant, bus.buf_in_addr, bus.buf_in_data});
        if (bus.buf_in_commit && bus.buf_in_wren) n_overlap++;
        if (bus.buf_in_commit && (bus.req0_ready || bus.req1_ready)) n_rdy_in_commit++;
        if (bus.buf_in_commit && !commit_prev) begin
          cl_q.push_back(bus.buf_in_commit_len);
          cg_q.push_back(bus.grant);
          commit_cyc = cyc;
          len_cap    = bus.buf_in_commit_len;
          n_commit++;
        end else if (bus.buf_in_commit && bus.buf_in_commit_len != len_cap) begin
          n_unstable++;
        end
        commit_prev = bus.buf_in_commit;
      end
    end
  end

  task automatic do_reset();
    @(negedge ext_clk);
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    src0.delete(); src1.delete();
    bus.buf_in_commit_ack = 1'b0;
    bus.buf_in_ready = 1'b1;
    ack_cnt = 0; ack_dly = 4; ack_hold = 1;
    repeat (2) @(negedge ext_clk);
    wr_q.delete(); cl_q.delete(); cg_q.delete();
    n_commit = 0; commit_prev = 1'b0; nacc0 = 0;
    n_overlap = 0; n_rdy_in_commit = 0; n_unstable = 0;
    reset = 1'b0;
  endtask

  task automatic wait_commits(input int n, input string tag);
    int k = 0;
    while (!(n_commit >= n && !bus.busy) && k < 200) begin
      @(negedge ext_clk);
      k++;
    end
    check_eq(tag, 32'(k < 200), 32'd1);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string tag);
    int k = 0;
    while (bus.grant != g && k < 50) begin
      @(negedge ext_clk);
      k++;
    end
    check_eq(tag, 32'(k < 50), 32'd1);
  endtask

  task automatic expect_wr(input int idx, input logic [18:0] exp);
    if (wr_q.size() > idx) check_eq($sformatf("wr%0d", idx), 32'(wr_q[idx]), 32'(exp));
    else check_eq($sformatf("wr%0d_missing", idx), 32'(wr_q.size()), 32'(idx + 1));
  endtask

  task automatic expect_commit(input int idx, input logic [9:0] len, input logic [1:0] g);
    if (cl_q.size() > idx) begin
      check_eq($sformatf("commit%0d_len", idx), 32'(cl_q[idx]), 32'(len));
      check_eq($sformatf("commit%0d_grant", idx), 32'(cg_q[idx]), 32'(g));
    end else begin
      check_eq($sformatf("commit%0d_missing", idx), 32'(cl_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    acc0 = 1'b0; acc1 = 1'b0;
    nacc0 = 0; last_acc = 0; n_commit = 0; commit_cyc = 0;
    bus.buf_in_ready = 1'b1;
    bus.buf_in_commit_ack = 1'b0;
    ack_dly = 4; ack_hold = 1; ack_cnt = 0;

    // Reset state
    do_reset();
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_commit", 32'(bus.buf_in_commit), 32'd0);
    check_eq("rst_len", 32'(bus.buf_in_commit_len), 32'd0);
    check_eq("rst_wren", 32'(bus.buf_in_wren), 32'd0);
    check_eq("rst_ready0", 32'(bus.req0_ready), 32'd0);

    // Single short packet from req0
    src0.push_back({1'b0, 8'hA1});
    src0.push_back({1'b0, 8'hA2});
    src0.push_back({1'b1, 8'hA3});
    en0 = 1'b1;
    wait_commits(1, "t1_wait");
    check_eq("t1_nwr", 32'(wr_q.size()), 32'd3);
    expect_wr(0, {2'b01, 9'd0, 8'hA1});
    expect_wr(1, {2'b01, 9'd1, 8'hA2});
    expect_wr(2, {2'b01, 9'd2, 8'hA3});
    expect_commit(0, 10'd3, 2'b01);
    check_eq("t1_commit_lat", 32'(commit_cyc - last_acc), 32'd1);
    check_eq("t1_grant_after", 32'(bus.grant), 32'd0);

    // Tie round-robin from reset
    do_reset();
    src0.push_back({1'b1, 8'hB0});
    src0.push_back({1'b1, 8'hB1});
    src1.push_back({1'b1, 8'hC0});
    src1.push_back({1'b1, 8'hC1});
    en0 = 1'b1; en1 = 1'b1;
    wait_commits(4, "t2_wait");
    expect_commit(0, 10'd1, 2'b01);
    expect_commit(1, 10'd1, 2'b10);
    expect_commit(2, 10'd1, 2'b01);
    expect_wr(2, {2'b01, 9'd0, 8'hB1});

    // Split transfer: MAX_LEN=4, req1 sends 6 bytes while req0 waits
    do_reset();
    for (int i = 0; i < 6; i++) src1.push_back({1'(i == 5), 8'(8'hE0 + i)});
    src0.push_back({1'b1, 8'hD0});
    en1 = 1'b1;
    wait_grant(2'b10, "t3_grant_wait");
    en0 = 1'b1;
    wait_commits(3, "t3_wait");
    expect_commit(0, 10'd4, 2'b10);
    expect_commit(1, 10'd2, 2'b10);
    expect_commit(2, 10'd1, 2'b01);
    expect_wr(3, {2'b10, 9'd3, 8'hE3});
    expect_wr(4, {2'b10, 9'd0, 8'hE4});
    expect_wr(5, {2'b10, 9'd1, 8'hE5});
    expect_wr(6, {2'b01, 9'd0, 8'hD0});

    // Ready gating
    do_reset();
    bus.buf_in_ready = 1'b0;
    src0.push_back({1'b0, 8'hF0});
    src0.push_back({1'b0, 8'hF1});
    src0.push_back({1'b1, 8'hF2});
    en0 = 1'b1;
    repeat (5) @(negedge ext_clk);
    check_eq("t4_grant_gated", 32'(bus.grant), 32'd0);
    check_eq("t4_ready0_gated", 32'(bus.req0_ready), 32'd0);
    check_eq("t4_busy_gated", 32'(bus.busy), 32'd0);
    bus.buf_in_ready = 1'b1;
    @(negedge ext_clk);
    check_eq("t4_grant_next", 32'(bus.grant), 32'd1);
    bus.buf_in_ready = 1'b0;
    wait_commits(1, "t4_wait");
    check_eq("t4_nwr", 32'(wr_q.size()), 32'd3);
    expect_commit(0, 10'd3, 2'b01);
    bus.buf_in_ready = 1'b1;

    // Handshake holds: slow ack, long ack-high
    do_reset();
    ack_dly = 20; ack_hold = 10;
    src0.push_back({1'b0, 8'h10});
    src0.push_back({1'b1, 8'h11});
    src1.push_back({1'b1, 8'h20});
    en0 = 1'b1; en1 = 1'b1;
    k = 0;
    while (!bus.buf_in_commit && k < 30) begin @(negedge ext_clk); k++; end
    check_eq("t5_commit_wait", 32'(k < 30), 32'd1);
    repeat (15) @(negedge ext_clk);
    check_eq("t5_commit_held", 32'(bus.buf_in_commit), 32'd1);
    check_eq("t5_len_held", 32'(bus.buf_in_commit_len), 32'd2);
    check_eq("t5_ready_held", 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    k = 0;
    while (bus.buf_in_commit && k < 30) begin @(negedge ext_clk); k++; end
    check_eq("t5_drop_wait", 32'(k < 30), 32'd1);
    repeat (5) @(negedge ext_clk);
    check_eq("t5_acklow_busy", 32'(bus.busy), 32'd1);
    check_eq("t5_acklow_grant", 32'(bus.grant), 32'd1);
    check_eq("t5_acklow_commit", 32'(bus.buf_in_commit), 32'd0);
    wait_commits(2, "t5_wait");
    expect_commit(1, 10'd1, 2'b10);
    check_eq("t5_rdy_in_commit", 32'(n_rdy_in_commit), 32'd0);
    check_eq("t5_unstable", 32'(n_unstable), 32'd0);
    check_eq("t5_overlap", 32'(n_overlap), 32'd0);

    // Reset mid-FILL after 2 of 5 bytes
    do_reset();
    ack_dly = 2; ack_hold = 1;
    for (int i = 0; i < 5; i++) src0.push_back({1'(i == 4), 8'(8'h30 + i)});
    en0 = 1'b1;
    k = 0;
    while (nacc0 < 2 && k < 30) begin @(negedge ext_clk); k++; end
    check_eq("t6_acc_wait", 32'(k < 30), 32'd1);
    reset = 1'b1;
    @(negedge ext_clk);
    check_eq("t6_grant", 32'(bus.grant), 32'd0);
    check_eq("t6_busy", 32'(bus.busy), 32'd0);
    check_eq("t6_wren", 32'(bus.buf_in_wren), 32'd0);
    check_eq("t6_commit", 32'(bus.buf_in_commit), 32'd0);
    check_eq("t6_ready0", 32'(bus.req0_ready), 32'd0);
    check_eq("t6_no_commit", 32'(n_commit), 32'd0);
    en0 = 1'b0;
    src0.delete();
    @(negedge ext_clk);
    reset = 1'b0;
    wr_q.delete(); cl_q.delete(); cg_q.delete();
    n_commit = 0; commit_prev = 1'b0;
    src0.push_back({1'b1, 8'h40});
    src1.push_back({1'b1, 8'h50});
    en0 = 1'b1; en1 = 1'b1;
    wait_commits(2, "t6_wait");
    expect_commit(0, 10'd1, 2'b01);
    expect_wr(0, {2'b01, 9'd0, 8'h40});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/usb2_ep_in_arbiter.md
# usb2_ep_in_arbiter

- Shares the single USB 2.0 IN endpoint buffer write port (buf_in_addr/data/wren, buf_in_commit/commit_len/commit_ack, buf_in_ready) between two byte-stream requesters.
- Lives in the ext_clk domain between user data sources and the buf_in_* ports of usb2_top.
- Packs each requester's stream into packets of at most MAX_LEN bytes, commits each packet with a four-phase handshake, and alternates ownership round-robin on transfer boundaries.

## Interface
Parameters:
- MAX_LEN, default 512: maximum bytes per committed packet. Legal range 1..512.

Ports:
- ext_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 byte valid.
- req0_data  in  8  requester 0 byte.
- req0_last  in  1  final byte of requester 0 transfer.
- req0_ready  out  1  requester 0 byte accepted when valid & ready.
- req1_valid, req1_data, req1_last, req1_ready: same as requester 0, for requester 1.
- buf_in_addr  out  9  write address.
- buf_in_data  out  8  write data.
- buf_in_wren  out  1  write strobe.
- buf_in_ready  in  1  endpoint buffer free.
- buf_in_commit  out  1  commit request, level.
- buf_in_commit_len  out  10  committed byte count.
- buf_in_commit_ack  in  1  commit acknowledge, level, from the phy_clk side.
- grant  out  2  one-hot current owner; 0 when idle.
- busy  out  1  state != IDLE.

## Operation
States: IDLE, FILL, COMMIT, ACK_LOW.

- **IDLE**
  - If buf_in_ready=1 and at least one reqN_valid=1, pick the owner and go to FILL.
  - If `hold` is set, the owner is the previous owner.
  - Otherwise, if both requesters are valid, the owner is the one not granted last (`last_grant`). If one is valid, it is that one.
  - Clear `count` on entry to FILL.
- **FILL**
  - reqN_ready = grant[N] & (state==FILL) & (count < MAX_LEN); combinational.
  - On accept: next cycle buf_in_wren=1, buf_in_addr=count[8:0], buf_in_data=byte; then count++.
  - The non-owner's ready stays 0.
- **Leaving FILL**
  - Accepted byte has last=1: clear `hold` and go to COMMIT.
  - Accepted byte makes count==MAX_LEN with last=0: set `hold` and go to COMMIT. The transfer continues in the next packet without re-arbitration.
- **COMMIT**
  - buf_in_commit=1, buf_in_commit_len=count (10-bit; MAX_LEN=512 gives 10'd512).
  - When buf_in_commit_ack=1, drop buf_in_commit and go to ACK_LOW.
- **ACK_LOW**
  - Wait for buf_in_commit_ack=0, then go to IDLE.
  - Update `last_grant`=owner; grant returns to 0.
- **buf_in_ready** is sampled only in IDLE. A deassertion during FILL, COMMIT or ACK_LOW is ignored.
- **No zero-length packets:** FILL is entered only with valid data, so count>=1 at commit.

## Timing
- **Reset values:** every output 0 (grant=2'b00, busy=0, buf_in_commit_len=0). Internal: state=IDLE, count=0, hold=0, last_grant=1, so requester 0 wins the first tie.
- **Reset mid-operation:** any in-progress packet or commit is abandoned and hold is cleared. The partial buffer contents are not committed.
- **IDLE to FILL:** the arbitration decision registers on the edge after the condition holds. grant, busy and reqN_ready are high in the following cycle.
- **Write latency:** byte accepted at edge t produces buf_in_wren/addr/data high for exactly the cycle after t. Throughput is 1 byte/cycle.
- **Commit latency:** last (or MAX_LEN-th) byte accepted at edge t:
  - final wren in cycle t+1;
  - buf_in_commit high from cycle t+2;
  - it never overlaps a wren.
- **Commit hold:** buf_in_commit and buf_in_commit_len stay stable until ack is sampled high. buf_in_commit drops the cycle after ack is seen.
- **Next arbitration:** IDLE is entered one cycle after ack is sampled low. The earliest next grant is one cycle later.
- **Simultaneous events:**
  - ack already high on COMMIT entry: commit is still asserted for at least 1 cycle.
  - requester valid deasserts mid-FILL: the arbiter waits in FILL with no timeout.

## Test plan
- **Single short packet:** req0 sends 3 bytes (0xA1, 0xA2, 0xA3; last on 0xA3), ack returns 4 cycles after commit.
  - wren at addr 0, 1, 2 with those data.
  - commit rises 2 cycles after the 0xA3 accept, commit_len=3.
  - grant=01 throughout, back to 00 after ack falls.
- **Tie round-robin:** both valid from reset, each sends 1 byte with last.
  - First packet is from req0 (grant=01), second from req1 (grant=10).
  - With both still valid, the third is from req0.
- **Split transfer, MAX_LEN=4:** req1 sends 6 bytes, req0 valid throughout.
  - Commit len=4, then req1 is re-granted despite req0 waiting.
  - Commit len=2, then req0 is granted.
- **Ready gating:** buf_in_ready=0 with req0 valid.
  - grant stays 00 and req0_ready=0.
  - Raising ready grants req0 the next cycle.
  - Dropping ready during FILL does not stall writes.
- **Handshake holds:** delay ack 20 cycles.
  - commit and len stay stable and no reqN_ready is asserted.
  - Holding ack high 10 cycles keeps the block in ACK_LOW (busy=1).
- **Reset mid-FILL:** reset after 2 of 5 bytes.
  - All outputs are 0 the next cycle and no commit is issued.
  - The next tie goes to req0.
